add_arb_sched: RTL and testbench
================================

Name: add_arb_sched

Overview:
- Round-robin scheduler that shares one pipelined 32-bit adder datapath (fixed LATENCY, no valid/reset of its own) among NREQ requesters.
- Issues at most one add per cycle and tracks each in-flight op with a valid/ID shift register matched to the adder latency.
- Captures results into a response FIFO, which returns them in issue order tagged with the requester ID.
- Credit accounting guarantees the FIFO never overflows, so the adder pipeline is never stalled.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 2, adder cycles from operands driven to sum valid (input reg + output reg).
- DEPTH, 4, response FIFO entries; must be >= LATENCY.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit set per cycle
- req_x  in  NREQ*32  operand x; requester i occupies bits [32i+31:32i]
- req_y  in  NREQ*32  operand y, same packing
- add_x  out  32  operand x to the adder
- add_y  out  32  operand y to the adder
- add_out  in  32  adder sum, valid LATENCY cycles after operands
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  clog2(NREQ)  requester ID of the head response
- rsp_sum  out  32  sum of the head response

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - rr_ptr = 0; tag shift register cleared (all invalid); FIFO empty; credit count = 0.
  - rsp_valid = 0, req_ready = 0, add_x = add_y = 0.
- Credit:
  - cnt = FIFO occupancy + in-flight ops, held in a register.
  - Issue is permitted when cnt < DEPTH.
  - cnt +1 on issue, -1 on pop. Issue and pop in the same cycle leave cnt unchanged.
  - Issue eligibility uses registered cnt only. A pop frees its credit next cycle, so there is no combinational path rsp_ready -> req_ready.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr and wrapping modulo NREQ; the first set bit wins, provided issue is permitted.
  - req_ready[win] = 1; add_x/add_y = req_x/req_y of the winner.
  - When nothing is issued, add_x/add_y = 0.
  - On issue, rr_ptr <= (win+1) mod NREQ. rr_ptr is unchanged when nothing is issued.
- Tag pipeline:
  - LATENCY-stage register of {valid, id}. Stage 0 is loaded with {issue, win}.
  - When the final stage is valid, push {id, add_out} into the FIFO in that cycle.
  - Issue-to-rsp_valid latency = LATENCY+1 cycles when the FIFO is empty (push registered).
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Simultaneous push and pop allowed at any occupancy, including full (credit guarantees no push into a full FIFO without a pop).
  - rsp_id/rsp_sum are the head entry; pop when rsp_valid & rsp_ready.
- Arithmetic: sum is modulo 2^32 (adder behaviour); no carry out.
- Ordering: responses are strictly in issue order, regardless of requester.
- Requester rules: a requester must hold req_valid and operands stable until req_ready. Dropping valid before grant is allowed and is simply not issued.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. Stale adder contents are ignored because the tags are invalid.
- Assertions for verification:
  - onehot0(req_ready).
  - cnt <= DEPTH.
  - No push into a full FIFO without a simultaneous pop.

Decomposition:
- Package add_arb_pkg holds:
  - WORD_W = 32.
  - The ID width function.
  - rsp_entry_t struct {id, sum}.
  - tag_t struct {valid, id}.
- One sub-module, add_arb_rsp_fifo: parameterised DEPTH FIFO of rsp_entry_t, with push/pop/full/empty/count.
- Arbitration, credit and tag pipeline stay in add_arb_sched.

Test Plan:
- Single op: req0 x=5, y=7 at cycle 0, rsp_ready=1 → req_ready=0001 at cycle 0; rsp_valid=1, rsp_id=0, rsp_sum=12 at cycle 3 for exactly one cycle.
- Round-robin fairness: all four requesters valid continuously with x=i, y=100 → grants 0,1,2,3,0,…; responses id 0,1,2,3 with sums 100,101,102,103.
- Wrap-around sum: x=0xFFFF_FFFF, y=2 → rsp_sum=0x0000_0001.
- Back-pressure: rsp_ready=0, all valid →
  - exactly 4 grants, then req_ready=0 continuously; FIFO holds 4 entries.
  - Raise rsp_ready → one pop per cycle, and new grants resume one cycle after each pop.
- Full with simultaneous push/pop: steady state with rsp_ready toggling 1/0 → no lost or duplicated response; scoreboard matches every issued {id, x+y} in order.
- Reset mid-flight: drop rst_n with 2 ops in flight and 1 in the FIFO → rsp_valid=0 immediately; after release, no stale responses appear and the next grant goes to requester 0.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
//   WORD_W      : datapath width of operands and sums.
//   ID_W_MAX    : storage width of requester IDs (covers up to 8 requesters).
//   id_width()  : bits needed to name one of n requesters.
//   rsp_entry_t : one response FIFO entry {id, sum}.
//   tag_t       : one stage of the in-flight tag pipeline {valid, id}.
package add_arb_pkg;

  localparam int WORD_W   = 32;
  localparam int ID_W_MAX = 3;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [WORD_W-1:0]   sum;
  } rsp_entry_t;

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/add_arb_rsp_fifo.sv
// Response FIFO: circular buffer of rsp_entry_t with wrapping pointers.
// Push and pop may occur together at any occupancy, including full.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the tail this cycle
//   push_data_i  : entry to write
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry
//   full_o       : all DEPTH entries occupied
//   empty_o      : no entries
//   count_o      : current occupancy
module add_arb_rsp_fifo
  import add_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  rsp_entry_t       push_data_i,
  input  logic             pop_i,
  output rsp_entry_t       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !pop_i));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && empty_o));
`endif

endmodule

// File: rtl/add_arb_sched.sv
// Round-robin scheduler sharing one pipelined adder among NREQ requesters.
// One add is issued per cycle at most; a {valid, id} tag pipeline matched to
// the adder latency captures each sum into a response FIFO, which returns
// results in issue order. A credit counter (FIFO occupancy + in-flight ops)
// keeps the FIFO from overflowing so the adder never has to stall.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester request handshake
//   req_x, req_y        : packed operands, requester i at [32i+31:32i]
//   add_x, add_y        : operands to the external adder (0 when idle)
//   add_out             : adder sum, valid LATENCY cycles after operands
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_sum     : requester ID and sum of the head response
//
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high. A requester holds req_valid and its operands stable until req_ready;
// dropping req_valid before a grant withdraws the request. req_ready depends
// only on req_valid and registered state, never on rsp_ready.
module add_arb_sched
  import add_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WORD_W-1:0]   req_x,
  input  logic [NREQ*WORD_W-1:0]   req_y,
  output logic [WORD_W-1:0]        add_x,
  output logic [WORD_W-1:0]        add_y,
  input  logic [WORD_W-1:0]        add_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WORD_W-1:0]        rsp_sum
);

  localparam int IDW   = id_width(NREQ);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  tag_t             tag_q [LATENCY];

  logic             issue_ok, issue, found, pop;
  logic [IDW-1:0]   win, cand;
  rsp_entry_t       push_data, head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_ok;

  // Arbitration: first valid requester at or after rr_ptr, wrapping.
  // Gating with rst_n keeps req_ready low while reset is asserted.
  always_comb begin
    issue_ok  = rst_n && (cnt_q < CNT_W'(DEPTH));
    found     = 1'b0;
    win       = '0;
    cand      = '0;
    req_ready = '0;
    add_x     = '0;
    add_y     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    issue = found && issue_ok;
    if (issue) begin
      req_ready[win] = 1'b1;
      add_x = req_x[int'(win)*WORD_W +: WORD_W];
      add_y = req_y[int'(win)*WORD_W +: WORD_W];
    end
  end

  assign pop = rsp_valid & rsp_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    // A pop returns its credit only from the next cycle on.
    case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      tag_q[0].valid <= issue;
      tag_q[0].id    <= ID_W_MAX'(win);
      for (int k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // The last tag stage lines up with the adder output for the same op.
  assign push_data.id  = tag_q[LATENCY-1].id;
  assign push_data.sum = add_out;

  add_arb_rsp_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tag_q[LATENCY-1].valid),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_id    = head.id[IDW-1:0];
  assign rsp_sum   = head.sum;

  // Spare ID bits and FIFO status only feed the checks below.
  assign unused_ok = ^{head.id, fifo_full, fifo_count};

`ifndef SYNTHESIS
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_W'(DEPTH));
  a_cnt_covers_fifo : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q >= fifo_count);
`endif

endmodule

// File: tb/tb_add_arb_sched.sv
module tb_add_arb_sched;

  localparam int NREQ    = 4;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_x, req_y;
  logic [31:0]       add_x, add_y, add_out;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_sum;

  always #5 clk = ~clk;

  add_arb_sched #(.NREQ(NREQ), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_out   (add_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  // External two-stage adder: input register then output register, no reset.
  logic [31:0] ax_q = '0, ay_q = '0, sum_q = '0;
  always @(posedge clk) begin
    ax_q  <= add_x;
    ay_q  <= add_y;
    sum_q <= ax_q + ay_q;
  end
  assign add_out = sum_q;

  // ---------------- reference model / scoreboard ----------------
  // exp_q holds {id, sum} of every issued op not yet popped, in issue order;
  // due_q holds the cycle its response becomes visible.
  logic [33:0] exp_q[$];
  int          due_q[$];
  int          rr_m = 0;
  int          cyc = 0;
  int          last_win = -1;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, exp);
    end
  endtask

  // Called just after a falling edge with inputs settled; checks every
  // output against the model, advances the model, moves to next falling edge.
  task automatic cycle();
    int          win;
    int          i;
    logic [31:0] e_x, e_y;
    logic        e_rv;
    #1;
    win = -1;
    if (rst_n && exp_q.size() < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (rr_m + k) % NREQ;
        if (win < 0 && req_valid[i]) win = i;
      end
    end
    e_x  = (win >= 0) ? req_x[win*32 +: 32] : 32'd0;
    e_y  = (win >= 0) ? req_y[win*32 +: 32] : 32'd0;
    e_rv = rst_n && (exp_q.size() > 0) && (due_q[0] <= cyc);
    chk("req_ready", 32'(req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
    chk("add_x", add_x, e_x);
    chk("add_y", add_y, e_y);
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    if (e_rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(exp_q[0][33:32]));
      chk("rsp_sum", rsp_sum, exp_q[0][31:0]);
      if (rsp_ready) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
    if (win >= 0) begin
      exp_q.push_back({2'(win), e_x + e_y});
      due_q.push_back(cyc + LATENCY + 1);
      rr_m = (win + 1) % NREQ;
    end
    last_win = win;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_add_x", add_x, 32'd0);
    chk("rst_add_y", add_y, 32'd0);
    exp_q.delete();
    due_q.delete();
    rr_m = 0;
    repeat (cycles) cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // Keeps operands stable while a request waits; refreshes after a grant.
  task automatic drive_reqs(input int p_drop);
    for (int i = 0; i < NREQ; i++) begin
      if (last_win == i || !req_valid[i]) begin
        req_valid[i]      = ($urandom_range(0, 3) != 0);
        req_x[i*32 +: 32] = rand_word();
        req_y[i*32 +: 32] = rand_word();
      end else if ($urandom_range(0, 15) < p_drop) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int cycles);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (cycles) cycle();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          id;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] sum;
    logic [3:0]  ready;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int grants;

    vecs[0] = '{0, 32'd5,          32'd7,          32'd12,         4'b0001};
    vecs[1] = '{1, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  4'b0010};
    vecs[2] = '{2, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  4'b0100};
    vecs[3] = '{3, 32'h1234_5678,  32'h1111_1111,  32'h2345_6789,  4'b1000};

    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Single ops: grant in the issue cycle, response exactly LATENCY+1 later.
    rsp_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      req_x[vecs[v].id*32 +: 32] = vecs[v].x;
      req_y[vecs[v].id*32 +: 32] = vecs[v].y;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(vecs[v].ready));
      cycle();
      req_valid = '0;
      for (int c = 1; c <= 4; c++) begin
        #1;
        chk("tbl_rsp_valid", 32'(rsp_valid), (c == 3) ? 32'd1 : 32'd0);
        if (c == 3) begin
          chk("tbl_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
          chk("tbl_rsp_sum", rsp_sum, vecs[v].sum);
        end
        cycle();
      end
    end

    // Round-robin fairness with all requesters continuously valid.
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*32 +: 32] = 32'(i);
      req_y[i*32 +: 32] = 32'd100;
    end
    req_valid = '1;
    for (int t = 0; t < 12; t++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'd1 << (t % 4));
      cycle();
    end
    drain(6);

    // Back-pressure: exactly DEPTH grants, then none until a pop.
    rsp_ready = 1'b0;
    req_valid = '1;
    grants = 0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (req_ready != '0) grants++;
      cycle();
    end
    chk("bp_grants", 32'(grants), 32'(DEPTH));
    rsp_ready = 1'b1;
    #1;
    chk("bp_pop_no_same_cycle_grant", 32'(req_ready), 32'd0);
    cycle();
    #1;
    chk("bp_grant_after_pop", 32'(req_ready != '0), 32'd1);
    repeat (8) cycle();
    drain(6);

    // Steady state near full with rsp_ready toggling.
    req_valid = '1;
    for (int t = 0; t < 80; t++) begin
      rsp_ready = t[0];
      cycle();
      drive_reqs(0);
    end
    // Fully random traffic, including withdrawn requests.
    for (int t = 0; t < 300; t++) begin
      rsp_ready = ($urandom_range(0, 2) != 0);
      cycle();
      drive_reqs(2);
    end
    drain(8);

    // Reset with two ops in flight and one in the FIFO.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int t = 0; t < 3; t++) begin
      req_x[32 +: 32] = 32'(t + 1);
      req_y[32 +: 32] = 32'd1000;
      cycle();
    end
    req_valid = '0;
    #1;
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    req_valid = '1;
    do_reset(2);
    #1;
    chk("post_reset_grant", 32'(req_ready), 32'd1);
    cycle();
    drain(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
